// File: rtl/issue_alu_dispatch.sv
// Issue-side transmitter for the issue->ALU interface: a small FIFO of decoded ALU
// instructions, dispatched as single-cycle strobes spaced by the ALU occupancy.
module issue_alu_dispatch #(
    parameter int DEPTH         = 4,
    parameter int ALU_OCCUPANCY = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_flush,
    input  logic [5:0]                 in_wfid,
    input  logic [31:0]                in_instr_pc,
    input  logic [31:0]                in_opcode,
    input  logic [15:0]                in_imm_value0,
    input  logic [31:0]                in_imm_value1,
    input  logic [11:0]                in_dest1_addr,
    input  logic [11:0]                in_dest2_addr,
    output logic                       out_alu_select,
    output logic [5:0]                 out_wfid,
    output logic [31:0]                out_instr_pc,
    output logic [31:0]                out_opcode,
    output logic [15:0]                out_imm_value0,
    output logic [31:0]                out_imm_value1,
    output logic [11:0]                out_dest1_addr,
    output logic [11:0]                out_dest2_addr,
    output logic [$clog2(DEPTH):0]     out_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (ALU_OCCUPANCY > 1) ? $clog2(ALU_OCCUPANCY) : 1;
    localparam int EW = 6 + 32 + 32 + 16 + 32 + 12 + 12;
    localparam logic [BW-1:0] BUSY_RELOAD = BW'(ALU_OCCUPANCY - 1);

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   wr_ptr_next, rd_ptr_next;
    logic [BW-1:0] busy_reg, busy_next;
    logic          full, empty, push, pop;
    logic [EW-1:0] wr_entry, head_entry;

    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // Flush wins over both push and dispatch in the same cycle.
    assign push = in_valid && !full && !in_flush;
    assign pop  = !empty && (busy_reg == '0) && !in_flush;

    assign in_ready  = !full;
    assign out_count = wr_ptr_reg - rd_ptr_reg;

    assign wr_entry   = {in_wfid, in_instr_pc, in_opcode, in_imm_value0,
                         in_imm_value1, in_dest1_addr, in_dest2_addr};
    assign head_entry = mem[rd_ptr_reg[AW-1:0]];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        busy_next   = busy_reg;
        if (in_flush) begin
            rd_ptr_next = wr_ptr_reg;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
        end
        // The occupancy countdown is independent of flush: the ALU is still busy.
        if (pop)
            busy_next = BUSY_RELOAD;
        else if (busy_reg != '0)
            busy_next = busy_reg - BW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst && push)
            mem[wr_ptr_reg[AW-1:0]] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            busy_reg       <= '0;
            out_alu_select <= 1'b0;
            out_wfid       <= '0;
            out_instr_pc   <= '0;
            out_opcode     <= '0;
            out_imm_value0 <= '0;
            out_imm_value1 <= '0;
            out_dest1_addr <= '0;
            out_dest2_addr <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            busy_reg       <= busy_next;
            out_alu_select <= pop;
            if (pop)
                {out_wfid, out_instr_pc, out_opcode, out_imm_value0,
                 out_imm_value1, out_dest1_addr, out_dest2_addr} <= head_entry;
        end
    end

endmodule
